// File: rtl/dmem_arbiter_pkg.sv
// dmem_arb_pkg: shared types, widths and range helper for the dmem arbiter
package dmem_arb_pkg;
  localparam int WORD = 32;
  localparam int AGE_W = 8;
  typedef enum logic [1:0] {RSP_NONE, RSP_C, RSP_D} rsp_state_e;
  function automatic logic addr_in_range(input logic [WORD-1:0] addr, input int power);
    return (addr >> power) == '0;
  endfunction
endpackage

// File: rtl/dmem_arbiter_if.sv
// dmem_arbiter_if: requester ports C/D plus the dmem bus
interface dmem_arbiter_if;
  import dmem_arb_pkg::*;
  logic c_req, c_we, c_gnt, c_rvalid, c_err;
  logic d_req, d_we, d_gnt, d_rvalid, d_err;
  logic [WORD-1:0] c_addr, c_wdata, c_rdata;
  logic [WORD-1:0] d_addr, d_wdata, d_rdata;
  logic mem_we;
  logic [WORD-1:0] mem_addr, mem_wdata, mem_rdata;
  modport slave (
    input c_req, c_we, c_addr, c_wdata, d_req, d_we, d_addr, d_wdata, mem_rdata,
    output c_gnt, c_rvalid, c_rdata, c_err, d_gnt, d_rvalid, d_rdata, d_err,
    output mem_we, mem_addr, mem_wdata
  );
  modport master (
    output c_req, c_we, c_addr, c_wdata, d_req, d_we, d_addr, d_wdata, mem_rdata,
    input c_gnt, c_rvalid, c_rdata, c_err, d_gnt, d_rvalid, d_rdata, d_err,
    input mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/dmem_arbiter_age_counter.sv
// arb_age_counter: saturating count of cycles port D has been blocked
module arb_age_counter
  import dmem_arb_pkg::*;
#(
  parameter int LIMIT = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             inc,
  output logic [AGE_W-1:0] cnt,
  output logic             starve
);
  logic [AGE_W-1:0] cnt_q, cnt_d;
  always_comb cnt_d = clr ? '0 : (inc && cnt_q != '1) ? cnt_q + 1'b1 : cnt_q;
  always_ff @(posedge clk) cnt_q <= rst ? '0 : cnt_d;
  assign cnt = cnt_q;
  assign starve = cnt_q >= AGE_W'(LIMIT);
endmodule

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: fixed-priority C / aged D sharing of single-port dmem
// with one registered response per accepted transaction.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int DMEM_POWER   = 18,
  parameter int STARVE_LIMIT = 4
) (
  input logic clk,
  input logic rst,
  dmem_arbiter_if.slave bus
);
  logic c_gnt, d_gnt, c_in, d_in, starve;
  logic [AGE_W-1:0] age_cnt;
  rsp_state_e state_q, state_d;
  logic [WORD-1:0] c_rdata_q, c_rdata_d, d_rdata_q, d_rdata_d;
  logic c_err_q, c_err_d, d_err_q, d_err_d;
  arb_age_counter #(.LIMIT(STARVE_LIMIT)) u_age (
    .clk(clk),
    .rst(rst),
    .clr(d_gnt || !bus.d_req),
    .inc(bus.d_req && !d_gnt),
    .cnt(age_cnt),
    .starve(starve)
  );
  always_comb begin
    c_in = addr_in_range(bus.c_addr, DMEM_POWER);
    d_in = addr_in_range(bus.d_addr, DMEM_POWER);
    d_gnt = !rst && bus.d_req && (starve || !bus.c_req);
    c_gnt = !rst && bus.c_req && !(bus.d_req && starve);
  end
  assign bus.c_gnt = c_gnt;
  assign bus.d_gnt = d_gnt;
  assign bus.mem_addr = d_gnt ? bus.d_addr : bus.c_addr;
  assign bus.mem_wdata = d_gnt ? bus.d_wdata : bus.c_wdata;
  assign bus.mem_we = d_gnt ? bus.d_we && d_in : c_gnt && bus.c_we && c_in;
  always_ff @(posedge clk) state_q <= rst ? RSP_NONE : state_d;
  always_comb state_d = c_gnt ? RSP_C : d_gnt ? RSP_D : RSP_NONE;
  // rst also masks rvalid so an in-flight response is dropped immediately
  always_comb begin
    bus.c_rvalid = state_q == RSP_C && !rst;
    bus.d_rvalid = state_q == RSP_D && !rst;
  end
  // writes leave rdata untouched; out-of-range reads return 0
  always_comb begin
    c_rdata_d = (c_gnt && !bus.c_we) ? (c_in ? bus.mem_rdata : '0) : c_rdata_q;
    d_rdata_d = (d_gnt && !bus.d_we) ? (d_in ? bus.mem_rdata : '0) : d_rdata_q;
    c_err_d = c_gnt ? !c_in : c_err_q;
    d_err_d = d_gnt ? !d_in : d_err_q;
  end
  always_ff @(posedge clk) begin
    c_rdata_q <= rst ? '0 : c_rdata_d;
    d_rdata_q <= rst ? '0 : d_rdata_d;
    c_err_q <= rst ? 1'b0 : c_err_d;
    d_err_q <= rst ? 1'b0 : d_err_d;
  end
  assign bus.c_rdata = c_rdata_q;
  assign bus.d_rdata = d_rdata_q;
  assign bus.c_err = c_err_q;
  assign bus.d_err = d_err_q;
endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: vector table, directed corner sequences and a
// randomized run against a rule-level reference model.
module tb_dmem_arbiter;
  localparam int LIM = 4;
  localparam int PWR = 18;
  logic clk = 1'b0;
  logic rst;
  int n_pass = 0;
  int n_total = 0;
  dmem_arbiter_if bus();
  dmem_arbiter #(.DMEM_POWER(PWR), .STARVE_LIMIT(LIM)) dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  logic [31:0] ram [0:(1<<PWR)-1];
  assign bus.mem_rdata = ram[bus.mem_addr[PWR-1:0]];
  always @(posedge clk) if (bus.mem_we) ram[bus.mem_addr[PWR-1:0]] <= bus.mem_wdata;

  typedef struct {
    logic cr, cw; logic [31:0] ca, cd;
    logic dr, dw; logic [31:0] da, dd;
    logic gc, gd, we, cv, dv; logic [31:0] crd; logic ce; logic [31:0] drd; logic de;
  } vec_t;
  vec_t v [10];

  function automatic vec_t mk(logic cr, cw, logic [31:0] ca, cd, logic dr, dw, logic [31:0] da, dd,
                              logic gc, gd, we, cv, dv, logic [31:0] crd, logic ce, logic [31:0] drd, logic de);
    vec_t r;
    r = '{cr, cw, ca, cd, dr, dw, da, dd, gc, gd, we, cv, dv, crd, ce, drd, de};
    return r;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s actual=%h required=%h at %0t", nm, act, exp, $time);
  endtask

  task automatic drive(input logic cr, cw, input logic [31:0] ca, cd, input logic dr, dw, input logic [31:0] da, dd);
    bus.c_req = cr; bus.c_we = cw; bus.c_addr = ca; bus.c_wdata = cd;
    bus.d_req = dr; bus.d_we = dw; bus.d_addr = da; bus.d_wdata = dd;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] rnd_addr();
    logic [31:0] a;
    a = 32'h100 + $urandom_range(0, 15);
    if ($urandom_range(0, 7) == 0) a = a | (32'h1 << $urandom_range(PWR, 31));
    return a;
  endfunction

  logic [31:0] ref_mem [int];
  function automatic logic [31:0] ref_rd(input logic [31:0] a);
    return ref_mem.exists(int'(a)) ? ref_mem[int'(a)] : 32'h0;
  endfunction

  initial begin
    logic c_hold, d_hold, pc_v, pd_v, pc_e, pd_e, ec, ed, c_inr, d_inr;
    logic [31:0] pc_d, pd_d;
    int wait_cnt;
    for (int i = 0; i < (1 << PWR); i++) ram[i] = 32'h0;
    ram[32'h10] = 32'hDEADBEEF;
    ref_mem[32'h10] = 32'hDEADBEEF;
    v[0] = mk(1,0,32'h10,0,       0,0,0,0,        1,0,0, 0,0, 0,0, 0,0);
    v[1] = mk(0,0,0,0,            0,0,0,0,        0,0,0, 1,0, 32'hDEADBEEF,0, 0,0);
    v[2] = mk(0,0,0,0,            1,1,32'h20,32'h1234, 0,1,1, 0,0, 0,0, 0,0);
    v[3] = mk(1,0,32'h20,0,       0,0,0,0,        1,0,0, 0,1, 0,0, 0,0);
    v[4] = mk(0,0,0,0,            0,0,0,0,        0,0,0, 1,0, 32'h1234,0, 0,0);
    v[5] = mk(1,1,32'h40000,5,    0,0,0,0,        1,0,0, 0,0, 0,0, 0,0);
    v[6] = mk(1,0,32'h40000,0,    0,0,0,0,        1,0,0, 1,0, 32'h1234,1, 0,0);
    v[7] = mk(0,0,0,0,            0,0,0,0,        0,0,0, 1,0, 0,1, 0,0);
    v[8] = mk(1,0,32'h10,0,       1,0,32'h20,0,   1,0,0, 0,0, 0,0, 0,0);
    v[9] = mk(0,0,0,0,            0,0,0,0,        0,0,0, 1,0, 32'hDEADBEEF,0, 0,0);
    rst = 1'b1;
    drive(1, 1, 32'h30, 32'hAAAA5555, 1, 1, 32'h31, 32'h5555AAAA);
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      chk("rst_c_gnt", bus.c_gnt, 0);
      chk("rst_d_gnt", bus.d_gnt, 0);
      chk("rst_mem_we", bus.mem_we, 0);
      chk("rst_c_rvalid", bus.c_rvalid, 0);
      chk("rst_d_rvalid", bus.d_rvalid, 0);
      if (k == 1) begin
        chk("rst_c_rdata", bus.c_rdata, 0);
        chk("rst_d_rdata", bus.d_rdata, 0);
        chk("rst_c_err", bus.c_err, 0);
        chk("rst_d_err", bus.d_err, 0);
      end
      next_cycle();
    end
    chk("rst_mem30", ram[32'h30], 0);
    chk("rst_mem31", ram[32'h31], 0);
    rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      drive(v[i].cr, v[i].cw, v[i].ca, v[i].cd, v[i].dr, v[i].dw, v[i].da, v[i].dd);
      @(negedge clk);
      chk($sformatf("vec%0d_c_gnt", i), bus.c_gnt, v[i].gc);
      chk($sformatf("vec%0d_d_gnt", i), bus.d_gnt, v[i].gd);
      chk($sformatf("vec%0d_mem_we", i), bus.mem_we, v[i].we);
      chk($sformatf("vec%0d_c_rvalid", i), bus.c_rvalid, v[i].cv);
      chk($sformatf("vec%0d_d_rvalid", i), bus.d_rvalid, v[i].dv);
      if (v[i].cv) begin
        chk($sformatf("vec%0d_c_rdata", i), bus.c_rdata, v[i].crd);
        chk($sformatf("vec%0d_c_err", i), bus.c_err, v[i].ce);
      end
      if (v[i].dv) begin
        chk($sformatf("vec%0d_d_rdata", i), bus.d_rdata, v[i].drd);
        chk($sformatf("vec%0d_d_err", i), bus.d_err, v[i].de);
      end
      next_cycle();
    end
    ref_mem[32'h20] = 32'h1234;
    for (int k = 0; k < 15; k++) begin
      drive(1, 0, 32'h10, 0, 1, 0, 32'h20, 0);
      @(negedge clk);
      chk($sformatf("starve%0d_d_gnt", k), bus.d_gnt, (k % 5) == 4);
      chk($sformatf("starve%0d_c_gnt", k), bus.c_gnt, (k % 5) != 4);
      next_cycle();
    end
    drive(0, 0, 0, 0, 1, 0, 32'h20, 0);
    @(negedge clk);
    chk("mid_d_gnt", bus.d_gnt, 1);
    next_cycle();
    rst = 1'b1;
    drive(1, 1, 32'h40, 32'h77, 1, 1, 32'h41, 32'h88);
    @(negedge clk);
    chk("mid_rst_d_rvalid", bus.d_rvalid, 0);
    chk("mid_rst_mem_we", bus.mem_we, 0);
    next_cycle();
    rst = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    chk("mid_after_d_rvalid", bus.d_rvalid, 0);
    chk("mid_age_cnt", 32'(dut.age_cnt), 0);
    chk("mid_mem40", ram[32'h40], 0);
    next_cycle();
    c_hold = 0; d_hold = 0; pc_v = 0; pd_v = 0; pc_e = 0; pd_e = 0;
    pc_d = 0; pd_d = 0; wait_cnt = 0;
    for (int k = 0; k < 3000; k++) begin
      if (!c_hold) begin
        bus.c_req = $urandom_range(0, 3) != 0; bus.c_we = $urandom_range(0, 1);
        bus.c_addr = rnd_addr(); bus.c_wdata = $urandom;
      end
      if (!d_hold) begin
        bus.d_req = $urandom_range(0, 1); bus.d_we = $urandom_range(0, 1);
        bus.d_addr = rnd_addr(); bus.d_wdata = $urandom;
      end
      @(negedge clk);
      ed = bus.d_req && (wait_cnt >= LIM || !bus.c_req);
      ec = bus.c_req && !ed;
      c_inr = bus.c_addr < (32'h1 << PWR);
      d_inr = bus.d_addr < (32'h1 << PWR);
      chk("rnd_c_gnt", bus.c_gnt, ec);
      chk("rnd_d_gnt", bus.d_gnt, ed);
      chk("rnd_one_gnt", bus.c_gnt && bus.d_gnt, 0);
      chk("rnd_mem_we", bus.mem_we, ec ? bus.c_we && c_inr : ed && bus.d_we && d_inr);
      if (ec) chk("rnd_mem_addr_c", bus.mem_addr, bus.c_addr);
      if (ed) chk("rnd_mem_addr_d", bus.mem_addr, bus.d_addr);
      chk("rnd_c_rvalid", bus.c_rvalid, pc_v);
      chk("rnd_d_rvalid", bus.d_rvalid, pd_v);
      if (pc_v) begin
        chk("rnd_c_rdata", bus.c_rdata, pc_d);
        chk("rnd_c_err", bus.c_err, pc_e);
      end
      if (pd_v) begin
        chk("rnd_d_rdata", bus.d_rdata, pd_d);
        chk("rnd_d_err", bus.d_err, pd_e);
      end
      pc_v = ec; pd_v = ed;
      if (ec) begin
        pc_e = !c_inr;
        if (!bus.c_we) pc_d = c_inr ? ref_rd(bus.c_addr) : 0;
        else if (c_inr) ref_mem[int'(bus.c_addr)] = bus.c_wdata;
      end
      if (ed) begin
        pd_e = !d_inr;
        if (!bus.d_we) pd_d = d_inr ? ref_rd(bus.d_addr) : 0;
        else if (d_inr) ref_mem[int'(bus.d_addr)] = bus.d_wdata;
      end
      wait_cnt = (ed || !bus.d_req) ? 0 : (wait_cnt < 255 ? wait_cnt + 1 : 255);
      c_hold = bus.c_req && !ec;
      d_hold = bus.d_req && !ed;
      next_cycle();
    end
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Shares the single-port data memory `dmem` between two requesters: the core load/store unit (port C) and the debug/loader port (port D). Port C has fixed priority. An aging counter guarantees port D forward progress. The block drives `dmem` write-enable, address and write data, and returns one registered response per accepted transaction. It sits between the pipeline MEM stage / debug unit and `dmem`.

## Interface
Parameters:
- `DMEM_POWER`, 18: number of word-address bits implemented by `dmem`.
- `STARVE_LIMIT`, 4: consecutive blocked cycles after which port D wins. Legal range 1..255.

Ports:
- `clk` in 1: single clock, rising edge.
- `rst` in 1: reset, synchronous and active-high.
- `c_req`, `d_req` in 1: request valid, per port.
- `c_we`, `d_we` in 1: 1 = write, 0 = read.
- `c_addr`, `d_addr` in `WORD`: word address.
- `c_wdata`, `d_wdata` in `WORD`: write data.
- `c_gnt`, `d_gnt` out 1: request accepted this cycle. Combinational.
- `c_rvalid`, `d_rvalid` out 1: response pulse, one per accepted transaction.
- `c_rdata`, `d_rdata` out `WORD`: read data. Registered.
- `c_err`, `d_err` out 1: out-of-range flag. Valid with `rvalid`.
- `mem_we` out 1: write enable to `dmem`.
- `mem_addr` out `WORD`: address to `dmem`.
- `mem_wdata` out `WORD`: write data to `dmem`.
- `mem_rdata` in `WORD`: combinational read data from `dmem`.

## Operation
- At most one transaction is accepted per cycle. A request is accepted in the cycle where `req && gnt`. Requesters hold `addr`, `we` and `wdata` stable until granted.
- Arbitration order:
  - `rst` forces both grants to 0.
  - If `d_req` and `age_cnt >= STARVE_LIMIT`, port D wins.
  - Else if `c_req`, port C wins.
  - Else if `d_req`, port D wins.
- Aging counter `age_cnt`, 8 bits:
  - Resets to 0.
  - Cleared when `d_gnt` or `!d_req`.
  - Incremented, saturating at 255, when `d_req && !d_gnt`.
- Memory drive: `mem_addr` and `mem_wdata` mux from the winning port. When there is no winner they hold port C's values.
- `mem_we` = winner's `we` && in-range && !`rst`.
- Out of range means any bit of `addr[WORD-1:DMEM_POWER]` is set. For such a transaction:
  - Writes are suppressed.
  - Reads return 0.
  - `err` = 1 in the response.
- Response register state machine, states `RSP_NONE`, `RSP_C`, `RSP_D`:
  - Next state is the port accepted this cycle, else `RSP_NONE`.
  - In `RSP_C` / `RSP_D`, the matching `rvalid` = 1.
- `rdata` update rules:
  - Reads: latch `mem_rdata`, or 0 if out of range, at the accept edge.
  - Writes: `rvalid` still pulses, `rdata` holds its previous value, `err` reflects the range check.
- Reset values: `c_rvalid`, `d_rvalid`, `c_err`, `d_err` = 0. `c_rdata`, `d_rdata` = 0. `age_cnt` = 0. State = `RSP_NONE`. `mem_we` = 0 while `rst` is high.

## Timing
- Grant latency is 0 cycles: `gnt` is combinational from `req`, `age_cnt` and `rst`.
- A write commits to `dmem` at the rising edge that ends the accept cycle.
- Response latency is 1 cycle: `rvalid` is high in the cycle after acceptance, for exactly 1 cycle.
- Back-to-back: a port may be accepted every cycle, with one response per cycle, pipelined.
- Read after write to the same address on consecutive cycles returns the new data, because `dmem` write is edge-committed and read is combinational.
- Simultaneous requests: only one `gnt` is ever high. Both grants high is a bench assertion failure.
- Reset mid-operation: an accepted-but-unanswered transaction is dropped. `rvalid` is 0 in the cycle after `rst`, and a write in the `rst` cycle is not committed.
- Port D worst-case wait under saturated port C is `STARVE_LIMIT` cycles.

## Structure
- Package `dmem_arb_pkg`:
  - enum `rsp_state_e` {`RSP_NONE`, `RSP_C`, `RSP_D`}.
  - `AGE_W` = 8.
  - Function `addr_in_range(addr, power)`.
- Sub-module `arb_age_counter`: saturating 8-bit counter with clear, increment and `>=` limit compare, output `starve`.
- Top: grant logic, memory mux, response state register, two response data/err registers. Target size 150–250 lines.

## Test plan
- Reset: assert `rst` for 2 cycles while `c_req` = `d_req` = 1 with writes → no grants, `mem_we` = 0, all outputs 0, memory unchanged.
- Single read: preload `RAM[0x10]` = `0xDEADBEEF`, then pulse `c_req` with read of `0x10` → `c_gnt` = 1 the same cycle; next cycle `c_rvalid` = 1, `c_rdata` = `0xDEADBEEF`, `c_err` = 0.
- Starvation: `STARVE_LIMIT` = 4, both ports request continuously from cycle 0 → grants C, C, C, C, D and repeat (D in cycles 4, 9, 14); never two grants at once.
- Write-then-read: D writes `0x1234` to `0x20` in cycle n, C reads `0x20` in cycle n+1 → `c_rdata` = `0x1234` in cycle n+2.
- Out of range: `DMEM_POWER` = 18, C writes to `0x0004_0000` → `mem_we` = 0, next cycle `c_rvalid` = 1, `c_err` = 1; a read of the same address returns 0 with `c_err` = 1.
- Reset mid-flight: D read accepted in cycle n, `rst` high in cycle n+1 → `d_rvalid` = 0 in n+1 and n+2, `age_cnt` = 0.
